// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multicycle controller: MIPS opcode/funct values,
// ALUOp encodings, FSM state encoding and the per-state Moore control table.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_FUNCT = 4'd2,
        ALU_AND   = 4'd3,
        ALU_OR    = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_LUI   = 4'd6,
        ALU_SLT   = 4'd7,
        ALU_SLTU  = 4'd8
    } alu_op_e;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_I_EXEC    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_JAL       = 4'd12,
        S_JR        = 4'd13
    } state_e;

    // Instruction class resolved in DECODE to pick the execute path.
    typedef enum logic [2:0] {
        CLS_MEM,
        CLS_RTYPE,
        CLS_JR,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_JAL,
        CLS_ITYPE,
        CLS_ILLEGAL
    } instr_class_e;

    typedef struct packed {
        logic    pc_write;
        logic    ir_write;
        logic    ior_d;
        logic    mem_read;
        logic    mem_write;
        logic    reg_write;
        logic    branch;
        logic    bne;
        logic    zero_ext;
        logic    alu_src_a;
        logic [1:0] pc_src;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_b;
        alu_op_e alu_op;
    } ctrl_t;

    // Moore control word for a state; anything not set stays 0.
    function automatic ctrl_t state_ctrl(input state_e s, input alu_op_e i_op,
                                         input logic i_zx, input logic is_bne);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.alu_op    = ALU_ADD;
            end
            S_DECODE:   c.alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = ALU_ADD;
            end
            S_MEM_READ: begin
                c.mem_read = 1'b1;
                c.ior_d    = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 2'b01;
            end
            S_MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.ior_d     = 1'b1;
            end
            S_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 2'b01;
            end
            S_I_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = i_op;
                c.zero_ext  = i_zx;
            end
            S_I_WB: begin
                c.reg_write = 1'b1;
                c.alu_op    = i_op;
                c.zero_ext  = i_zx;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_SUB;
                c.pc_src    = 2'b01;
                c.branch    = ~is_bne;
                c.bne       = is_bne;
            end
            S_JUMP: begin
                c.pc_write = 1'b1;
                c.pc_src   = 2'b10;
            end
            S_JAL: begin
                c.pc_write   = 1'b1;
                c.pc_src     = 2'b10;
                c.reg_write  = 1'b1;
                c.reg_dst    = 2'b10;
                c.mem_to_reg = 2'b10;
            end
            S_JR: begin
                c.pc_write = 1'b1;
                c.pc_src   = 2'b11;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and memory handshake in,
// control strobes, state and retire counter out.
interface mc_ctrl_if #(
    parameter int unsigned ALUOP_W = 4,
    parameter int unsigned CNT_W   = 32
);
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic               memReady;

    logic               pcWrite;
    logic               irWrite;
    logic               iorD;
    logic               memRead;
    logic               memWrite;
    logic               regWrite;
    logic               branch;
    logic               bne;
    logic               zeroExt;
    logic               aluSrcA;
    logic [1:0]         pcSrc;
    logic [1:0]         regDst;
    logic [1:0]         memToReg;
    logic [1:0]         aluSrcB;
    logic [ALUOP_W-1:0] ALUOp;
    logic [3:0]         state;
    logic               illegalOp;
    logic [CNT_W-1:0]   instrCount;

    modport master (
        input  opcode, funct, memReady,
        output pcWrite, irWrite, iorD, memRead, memWrite, regWrite, branch, bne,
               zeroExt, aluSrcA, pcSrc, regDst, memToReg, aluSrcB, ALUOp,
               state, illegalOp, instrCount
    );

    modport slave (
        output opcode, funct, memReady,
        input  pcWrite, irWrite, iorD, memRead, memWrite, regWrite, branch, bne,
               zeroExt, aluSrcA, pcSrc, regDst, memToReg, aluSrcB, ALUOp,
               state, illegalOp, instrCount
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode decode: instruction class, I-type ALUOp/zero-extend,
// and the load/bne qualifiers used later in the instruction.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0]   opcode_i,
    input  logic [5:0]   funct_i,
    output instr_class_e cls_o,
    output alu_op_e      alu_op_o,
    output logic         zero_ext_o,
    output logic         is_load_o,
    output logic         is_bne_o
);

    assign is_load_o = (opcode_i == OP_LW);
    assign is_bne_o  = (opcode_i == OP_BNE);

    // Classify the opcode and pick the immediate-path ALU operation.
    always_comb begin
        cls_o      = CLS_ILLEGAL;
        alu_op_o   = ALU_ADD;
        zero_ext_o = 1'b0;
        case (opcode_i)
            OP_RTYPE: cls_o = (funct_i == FN_JR) ? CLS_JR : CLS_RTYPE;
            OP_LW,
            OP_SW:    cls_o = CLS_MEM;
            OP_BEQ,
            OP_BNE:   cls_o = CLS_BRANCH;
            OP_J:     cls_o = CLS_JUMP;
            OP_JAL:   cls_o = CLS_JAL;
            OP_ADDI:  cls_o = CLS_ITYPE;
            OP_ANDI: begin
                cls_o      = CLS_ITYPE;
                alu_op_o   = ALU_AND;
                zero_ext_o = 1'b1;
            end
            OP_ORI: begin
                cls_o      = CLS_ITYPE;
                alu_op_o   = ALU_OR;
                zero_ext_o = 1'b1;
            end
            OP_XORI: begin
                cls_o      = CLS_ITYPE;
                alu_op_o   = ALU_XOR;
                zero_ext_o = 1'b1;
            end
            OP_LUI: begin
                cls_o    = CLS_ITYPE;
                alu_op_o = ALU_LUI;
            end
            OP_SLTI: begin
                cls_o    = CLS_ITYPE;
                alu_op_o = ALU_SLT;
            end
            OP_SLTIU: begin
                cls_o    = CLS_ITYPE;
                alu_op_o = ALU_SLTU;
            end
            default: cls_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM with memory wait states and a retired-instruction
// counter.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W = 4,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned MEM_HS  = 1
) (
    input  logic      clk,
    input  logic      rst,
    mc_ctrl_if.master bus
);

    state_e       state_q, state_d;
    ctrl_t        ctrl_q;
    logic [CNT_W-1:0] cnt_q;

    instr_class_e cls;
    alu_op_e      dec_alu_op;
    logic         dec_zx;
    logic         dec_load;
    logic         dec_bne;
    logic         mem_rdy;
    logic         retire;
    logic         fetch_gate;

    mc_ctrl_decode u_decode (
        .opcode_i   (bus.opcode),
        .funct_i    (bus.funct),
        .cls_o      (cls),
        .alu_op_o   (dec_alu_op),
        .zero_ext_o (dec_zx),
        .is_load_o  (dec_load),
        .is_bne_o   (dec_bne)
    );

    assign mem_rdy = (MEM_HS != 0) ? bus.memReady : 1'b1;

    // Next-state selection; memory states hold until the handshake completes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_rdy) state_d = S_DECODE;
            S_DECODE: begin
                case (cls)
                    CLS_MEM:    state_d = S_MEM_ADDR;
                    CLS_RTYPE:  state_d = S_R_EXEC;
                    CLS_JR:     state_d = S_JR;
                    CLS_BRANCH: state_d = S_BRANCH;
                    CLS_JUMP:   state_d = S_JUMP;
                    CLS_JAL:    state_d = S_JAL;
                    CLS_ITYPE:  state_d = S_I_EXEC;
                    default:    state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = dec_load ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (mem_rdy) state_d = S_MEM_WB;
            S_MEM_WRITE: if (mem_rdy) state_d = S_FETCH;
            S_R_EXEC:    state_d = S_R_WB;
            S_I_EXEC:    state_d = S_I_WB;
            default:     state_d = S_FETCH;
        endcase
    end

    // DECODE only returns to FETCH for an illegal opcode, which does not retire.
    assign retire = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_DECODE);

    // State, registered Moore control word (decoded from the next state so it
    // lines up with state_q) and the retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            ctrl_q  <= state_ctrl(S_FETCH, dec_alu_op, dec_zx, dec_bne);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d, dec_alu_op, dec_zx, dec_bne);
            if (retire) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // FETCH only commits PC/IR in the cycle memory delivers the instruction.
    assign fetch_gate = (state_q != S_FETCH) || mem_rdy;

    assign bus.pcWrite    = ctrl_q.pc_write & fetch_gate & ~rst;
    assign bus.irWrite    = ctrl_q.ir_write & fetch_gate & ~rst;
    assign bus.memRead    = ctrl_q.mem_read  & ~rst;
    assign bus.memWrite   = ctrl_q.mem_write & ~rst;
    assign bus.regWrite   = ctrl_q.reg_write & ~rst;
    assign bus.illegalOp  = (state_q == S_DECODE) && (cls == CLS_ILLEGAL) && !rst;
    assign bus.iorD       = ctrl_q.ior_d;
    assign bus.branch     = ctrl_q.branch;
    assign bus.bne        = ctrl_q.bne;
    assign bus.zeroExt    = ctrl_q.zero_ext;
    assign bus.aluSrcA    = ctrl_q.alu_src_a;
    assign bus.pcSrc      = ctrl_q.pc_src;
    assign bus.regDst     = ctrl_q.reg_dst;
    assign bus.memToReg   = ctrl_q.mem_to_reg;
    assign bus.aluSrcB    = ctrl_q.alu_src_b;
    assign bus.ALUOp      = ALUOP_W'(ctrl_q.alu_op);
    assign bus.state      = state_q;
    assign bus.instrCount = cnt_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter ALUOP_W, default 4, ALUOp output width (>=4; upper bits zero).
REQ-002 SHALL have parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-003 SHALL have parameter MEM_HS, default 1; 1 = honour memReady, 0 = memReady treated as constant 1.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port opcode, input, 6, instruction bits 31-26 from the instruction register.
REQ-007 SHALL have port funct, input, 6, instruction bits 5-0.
REQ-008 SHALL have port memReady, input, 1, memory access completes this cycle.
REQ-009 SHALL have outputs pcWrite, irWrite, iorD, memRead, memWrite, regWrite, branch, bne, zeroExt, aluSrcA, each 1 bit.
REQ-010 SHALL have outputs pcSrc, regDst, memToReg, aluSrcB, each 2 bits.
REQ-011 SHALL have output ALUOp, ALUOP_W bits: 0 add, 1 sub, 2 R-type/funct, 3 and, 4 or, 5 xor, 6 lui, 7 slt, 8 sltu.
REQ-012 SHALL have outputs state (4 bits), illegalOp (1 bit pulse), instrCount (CNT_W bits).

Function
REQ-013 SHALL implement states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, JAL, JR; all outputs Moore-decoded from state, except the memReady gating below.
REQ-014 FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, ALUOp=add; irWrite=pcWrite=memReady; advance to DECODE only when memReady=1, else hold.
REQ-015 DECODE: aluSrcA=0, aluSrcB=11 (branch target precompute); next state by opcode: LW/SW->MEM_ADDR, R-type funct!=JR->R_EXEC, R-type funct=JR->JR, BEQ/BNE->BRANCH, J->JUMP, JAL->JAL, ADDI/ANDI/ORI/XORI/LUI/SLTI/SLTIU->I_EXEC, any other opcode->FETCH with illegalOp=1 for exactly that cycle.
REQ-016 MEM_ADDR: aluSrcA=1, aluSrcB=10, ALUOp=add; next MEM_READ (LW) or MEM_WRITE (SW).
REQ-017 MEM_READ: memRead=1, iorD=1; hold until memReady, then MEM_WB. MEM_WB: regWrite=1, regDst=00, memToReg=01; next FETCH.
REQ-018 MEM_WRITE: memWrite=1, iorD=1; hold until memReady, then FETCH; memWrite stays high while holding.
REQ-019 R_EXEC: aluSrcA=1, aluSrcB=00, ALUOp=2; R_WB: regWrite=1, regDst=01, memToReg=00; then FETCH.
REQ-020 I_EXEC: aluSrcA=1, aluSrcB=10, ALUOp per opcode (ADDI add, ANDI and, ORI or, XORI xor, LUI lui, SLTI slt, SLTIU sltu), zeroExt=1 only for ANDI/ORI/XORI; I_WB: regWrite=1, regDst=00, memToReg=00, same ALUOp/zeroExt held; then FETCH.
REQ-021 BRANCH: aluSrcA=1, aluSrcB=00, ALUOp=sub, pcSrc=01, branch=1 (BEQ) or bne=1 (BNE); datapath gates pcWrite with zero; next FETCH.
REQ-022 JUMP: pcWrite=1, pcSrc=10; JAL: additionally regWrite=1, regDst=10, memToReg=10; JR: pcWrite=1, pcSrc=11; each next FETCH.
REQ-023 Latency without wait states: BEQ/BNE/J/JAL/JR 3 cycles, R-type/SW/I-type 4, LW 5; each memReady=0 cycle in a memory state adds one cycle.
REQ-024 instrCount SHALL increment by 1 on each transition into FETCH from any state other than DECODE-illegal; wraps modulo 2^CNT_W.
REQ-025 All outputs not listed for a state SHALL be 0.

Reset
REQ-026 rst=1 at a rising edge SHALL force state=FETCH and instrCount=0, overriding any transition or memReady, including mid-access.
REQ-027 While rst=1, pcWrite, irWrite, memRead, memWrite, regWrite and illegalOp SHALL be 0.

Structure
REQ-028 Opcode/funct constants, ALUOp encodings and state encoding SHALL live in shared package mc_ctrl_pkg.
REQ-029 Opcode-to-ALUOp/zeroExt decode SHALL be sub-module mc_ctrl_decode (combinational), instantiated once.

Verification
REQ-030 Reset then ADD (opcode 0, funct 0x20), memReady=1: states FETCH,DECODE,R_EXEC,R_WB; regWrite=1, regDst=01 in cycle 4; instrCount=1.
REQ-031 LW with memReady=0 for 2 cycles in FETCH and 3 in MEM_READ: 10 cycles total, irWrite asserted exactly once.
REQ-032 ORI 0x0D: zeroExt=1, ALUOp=4 in I_EXEC and I_WB; SLTIU 0x0B: zeroExt=0, ALUOp=8.
REQ-033 Opcode 0x3F: DECODE->FETCH, illegalOp pulse 1 cycle, no write enable, instrCount unchanged.
REQ-034 rst asserted during MEM_WRITE hold: next cycle state=FETCH, memWrite=0, instrCount=0.
REQ-035 CNT_W=4: 16 J instructions wrap instrCount to 0; JAL shows regDst=10, memToReg=10, pcSrc=10.
